note_lane_renderer: RTL and testbench

- Parameterised successor to the fixed 3-row, 30-square note scanner.
- Walks every pixel of every note square across LANES lanes × SLOTS slots and emits one VGA plot per cycle. Colour is the lane colour where the note bit is set, black otherwise.
- Sits between the note shifters and the VGA adapter; one start pulse redraws the whole track.
- Adds what the old scanner lacked: full-square pixel walk, per-lane colour table, start/busy/done handshake, input snapshot and clear mode.

---
 rtl/draw_pkg.sv | 25 ++
 rtl/square_pixel_counter.sv | 43 ++++
 rtl/note_lane_renderer.sv | 182 ++++++++++++++++++
 tb/tb_note_lane_renderer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared drawing definitions for the note track renderer.
// Provides the 3-bit RGB colour constants, the VGA canvas limits and the
// renderer FSM state encoding. No ports.
package draw_pkg;

  // 3-bit colour, bit 2 = red, bit 1 = green, bit 0 = blue
  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } draw_state_t;

endpackage

// File: rtl/square_pixel_counter.sv
// Walks the pixels of one SQ x SQ square, px innermost, one step per enabled
// cycle; both counters wrap back to 0 after the last pixel.
// Ports:
//   clk   - clock
//   reset - synchronous active-high clear of px/py
//   en    - advance one pixel this cycle
//   px    - pixel column within the square
//   py    - pixel row within the square
//   last  - high while px = py = SQ-1
module square_pixel_counter #(
  parameter int SQ = 4,
  localparam int CW = (SQ > 1) ? $clog2(SQ) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] px,
  output logic [CW-1:0] py,
  output logic          last
);

  logic px_last;
  logic py_last;

  assign px_last = (px == CW'(SQ - 1));
  assign py_last = (py == CW'(SQ - 1));
  assign last    = px_last && py_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      px <= '0;
      py <= '0;
    end else if (en) begin
      if (px_last) begin
        px <= '0;
        py <= py_last ? '0 : py + CW'(1);
      end else begin
        px <= px + CW'(1);
      end
    end
  end

endmodule

// File: rtl/note_lane_renderer.sv
// Redraws the whole note track on one start pulse: every pixel of every
// square across LANES x SLOTS is emitted as one VGA plot per cycle, coloured
// with the lane colour where the note bit is set and black otherwise.
// Inputs are snapshotted at start so the shifters may move during a pass.
// Ports:
//   clk          - clock
//   reset        - synchronous active-high reset
//   start        - begins a pass when idle
//   clear        - sampled with start; forces every pixel black
//   lane_bits    - note bits, lane l slot s at bit l*SLOTS+s
//   lane_colours - lane l colour at bits [3l+2:3l]
//   plot_x/y     - pixel coordinate
//   plot_colour  - pixel colour
//   plot         - plot_x/y/colour valid this cycle
//   busy         - pass in progress
//   done         - one-cycle pulse after the last pixel
//
// state   | meaning
// IDLE    | waiting for start; snapshot taken on leaving
// DRAW    | one pixel per cycle from the snapshot
// DONE    | done pulse, then back to IDLE
module note_lane_renderer
  import draw_pkg::*;
#(
  parameter int LANES = 3,
  parameter int SLOTS = 30,
  parameter int SQ    = 4,
  parameter int PITCH = 5,
  parameter int X0    = 1,
  parameter int Y0    = 53
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear,
  input  logic [LANES*SLOTS-1:0] lane_bits,
  input  logic [3*LANES-1:0]     lane_colours,
  output logic [7:0]             plot_x,
  output logic [6:0]             plot_y,
  output logic [2:0]             plot_colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = (SQ > 1) ? $clog2(SQ) : 1;
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  if (X0 + (SLOTS - 1) * PITCH + SQ - 1 > SCREEN_W - 1) begin : g_x_range
    $error("note_lane_renderer: track exceeds screen width");
  end
  if (Y0 + (LANES - 1) * PITCH + SQ - 1 > SCREEN_H - 1) begin : g_y_range
    $error("note_lane_renderer: track exceeds screen height");
  end
  if (PITCH < SQ) begin : g_pitch
    $error("note_lane_renderer: PITCH must be at least SQ");
  end

  draw_state_t state, state_next;

  logic          accept;
  logic          draw_en;
  logic [CW-1:0] px, py;
  logic          sq_last;
  logic [SW-1:0] slot;
  logic [LW-1:0] lane;
  logic          slot_last;
  logic          lane_last;
  logic          frame_last;

  logic          snap_clear;
  logic [2:0]    snap_colour [LANES];
  logic          snap_bits   [LANES][SLOTS];

  logic          plot_d, busy_d, done_d;
  logic [7:0]    x_d;
  logic [6:0]    y_d;
  logic [2:0]    c_d;

  assign accept     = (state == ST_IDLE) && start;
  assign draw_en    = (state == ST_DRAW);
  assign slot_last  = (slot == SW'(SLOTS - 1));
  assign lane_last  = (lane == LW'(LANES - 1));
  assign frame_last = draw_en && sq_last && slot_last && lane_last;

  // Counters wrap to 0 at the end of every pass, so the clear on accept
  // only matters after an odd reset; it keeps the first pixel well defined.
  square_pixel_counter #(.SQ(SQ)) u_sq (
    .clk   (clk),
    .reset (reset | accept),
    .en    (draw_en),
    .px    (px),
    .py    (py),
    .last  (sq_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_DRAW;
      ST_DRAW: if (frame_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    plot_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    x_d    = '0;
    y_d    = '0;
    c_d    = BLACK;
    unique case (state)
      ST_DRAW: begin
        plot_d = 1'b1;
        busy_d = 1'b1;
        // modular 8/7-bit arithmetic equals full-width result truncated
        x_d = 8'(X0) + 8'(slot) * 8'(PITCH) + 8'(px);
        y_d = 7'(Y0) + 7'(lane) * 7'(PITCH) + 7'(py);
        if (!snap_clear && snap_bits[lane][slot]) c_d = snap_colour[lane];
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      slot <= '0;
      lane <= '0;
    end else if (draw_en && sq_last) begin
      if (slot_last) begin
        slot <= '0;
        lane <= lane_last ? '0 : lane + LW'(1);
      end else begin
        slot <= slot + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_clear <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        snap_colour[l] <= BLACK;
        for (int s = 0; s < SLOTS; s++) snap_bits[l][s] <= 1'b0;
      end
    end else if (accept) begin
      snap_clear <= clear;
      for (int l = 0; l < LANES; l++) begin
        snap_colour[l] <= lane_colours[3*l +: 3];
        for (int s = 0; s < SLOTS; s++) snap_bits[l][s] <= lane_bits[l*SLOTS + s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      plot        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= BLACK;
    end else begin
      plot        <= plot_d;
      busy        <= busy_d;
      done        <= done_d;
      plot_x      <= x_d;
      plot_y      <= y_d;
      plot_colour <= c_d;
    end
  end

endmodule

// File: tb/tb_note_lane_renderer.sv
module tb_note_lane_renderer;

  localparam int NB   = 90;
  localparam int NPIX = 1440;

  localparam logic [2:0] C_RED    = 3'b100;
  localparam logic [2:0] C_YELLOW = 3'b110;
  localparam logic [2:0] C_BLUE   = 3'b001;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          clear;
  logic [NB-1:0] lane_bits;
  logic [8:0]    lane_colours;
  logic [7:0]    plot_x;
  logic [6:0]    plot_y;
  logic [2:0]    plot_colour;
  logic          plot;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] cap_x [4096];
  logic [6:0] cap_y [4096];
  logic [2:0] cap_c [4096];
  int   cap_n, done_k, done_k2, done_cnt, stray;
  logic rst_plot, rst_busy;

  note_lane_renderer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .clear        (clear),
    .lane_bits    (lane_bits),
    .lane_colours (lane_colours),
    .plot_x       (plot_x),
    .plot_y       (plot_y),
    .plot_colour  (plot_colour),
    .plot         (plot),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic int exp_x(int i);
    return 1 + ((i / 16) % 30) * 5 + (i % 4);
  endfunction

  function automatic int exp_y(int i);
    return 53 + (i / 480) * 5 + ((i / 4) % 4);
  endfunction

  function automatic logic [2:0] exp_c(int i, logic [NB-1:0] bits, logic [8:0] cols, logic clr);
    int idx;
    idx = (i / 480) * 30 + (i / 16) % 30;
    if (clr || !bits[idx]) return 3'b000;
    return cols[(i / 480) * 3 +: 3];
  endfunction

  // Pulse start, then watch up to max_cycles cycles after the accepting edge.
  // k counts cycles after that edge. Optional mid-pass flip+restart, reset,
  // or a new start issued in the done cycle.
  task automatic run_pass(input int max_cycles, input int flip_at, input int reset_at,
                          input bit chain);
    int need, tail;
    need = chain ? 2 : 1;
    tail = 0;
    cap_n = 0; done_k = 0; done_k2 = 0; done_cnt = 0; stray = 0;
    rst_plot = 1'b1; rst_busy = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= max_cycles; k++) begin
      @(negedge clk);
      if (plot) begin
        if (cap_n < 4096) begin
          cap_x[cap_n] = plot_x;
          cap_y[cap_n] = plot_y;
          cap_c[cap_n] = plot_colour;
        end
        cap_n++;
      end
      if (plot && !busy) stray++;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) done_k = k;
        if (done_cnt == 2) done_k2 = k;
      end
      if (k == reset_at + 1) begin
        rst_plot = plot;
        rst_busy = busy;
        reset = 1'b0;
      end
      start = 1'b0;
      if (k == flip_at) begin
        lane_bits = ~lane_bits;
        start = 1'b1;
      end
      if (k == reset_at) reset = 1'b1;
      if (chain && done && done_cnt == 1) start = 1'b1;
      if (done_cnt >= need) begin
        tail++;
        if (tail > 3) break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({plot, busy, done, plot_x, plot_y, plot_colour} !== 21'd0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: plot=%b busy=%b done=%b x=%0d y=%0d c=%0d, required all 0",
                 c, plot, busy, done, plot_x, plot_y, plot_colour);
      end
    end
  endtask

  task automatic test_first_bit;
    int bad16, black, coord_bad;
    lane_bits = '0;
    lane_bits[0] = 1'b1;
    lane_colours = {C_BLUE, C_YELLOW, C_RED};
    run_pass(1600, -1, -1, 1'b0);

    bad16 = 0;
    for (int i = 0; i < 16; i++)
      if (cap_x[i] !== 8'(1 + i % 4) || cap_y[i] !== 7'(53 + i / 4) || cap_c[i] !== C_RED) bad16++;
    n_checks++;
    if (bad16 != 0) begin
      n_fail++;
      $display("FAIL first16: %0d of first 16 plots wrong, required 0", bad16);
    end

    n_checks++;
    if (cap_x[16] !== 8'd6 || cap_y[16] !== 7'd53 || cap_c[16] !== 3'b000) begin
      n_fail++;
      $display("FAIL plot17: x=%0d y=%0d c=%0d, required x=6 y=53 c=0", cap_x[16], cap_y[16], cap_c[16]);
    end

    n_checks++;
    if (cap_n != NPIX) begin
      n_fail++;
      $display("FAIL plot_count: got %0d, required %0d", cap_n, NPIX);
    end

    n_checks++;
    if (done_k != 1441 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL done_timing: first done at %0d (count %0d), required 1441 (count 1)", done_k, done_cnt);
    end

    black = 0;
    coord_bad = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (cap_c[i] === 3'b000) black++;
      if (cap_x[i] !== 8'(exp_x(i)) || cap_y[i] !== 7'(exp_y(i))) coord_bad++;
    end
    n_checks++;
    if (black != 1424) begin
      n_fail++;
      $display("FAIL black_count: got %0d, required 1424", black);
    end
    n_checks++;
    if (coord_bad != 0) begin
      n_fail++;
      $display("FAIL walk_order: %0d coordinates wrong, required 0", coord_bad);
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL plot_without_busy: %0d cycles, required 0", stray);
    end
  endtask

  task automatic test_last_bit;
    int bad, blue;
    lane_bits = '0;
    lane_bits[89] = 1'b1;
    lane_colours = {C_BLUE, C_YELLOW, C_RED};
    run_pass(1600, -1, -1, 1'b0);
    bad = 0;
    for (int i = 1424; i < NPIX; i++)
      if (cap_x[i] !== 8'(146 + i % 4) || cap_y[i] !== 7'(63 + (i - 1424) / 4) || cap_c[i] !== C_BLUE)
        bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL last16: %0d of final 16 plots wrong, required 0", bad);
    end
    blue = 0;
    for (int i = 0; i < NPIX; i++) if (cap_c[i] === C_BLUE) blue++;
    n_checks++;
    if (blue != 16 || cap_n != NPIX) begin
      n_fail++;
      $display("FAIL last_blue_count: blue=%0d plots=%0d, required 16 and 1440", blue, cap_n);
    end
  endtask

  task automatic test_clear;
    int lit;
    lane_bits = '1;
    lane_colours = {C_BLUE, C_YELLOW, C_RED};
    clear = 1'b1;
    run_pass(1600, -1, -1, 1'b0);
    clear = 1'b0;
    lit = 0;
    for (int i = 0; i < NPIX; i++) if (cap_c[i] !== 3'b000) lit++;
    n_checks++;
    if (lit != 0 || cap_n != NPIX) begin
      n_fail++;
      $display("FAIL clear_mode: non-black=%0d plots=%0d, required 0 and 1440", lit, cap_n);
    end
  endtask

  task automatic test_snapshot;
    logic [NB-1:0] orig;
    logic [8:0]    cols;
    int bad;
    for (int i = 0; i < NB; i++) orig[i] = (i % 3 == 0) || (i % 7 == 2);
    cols = {3'b011, 3'b101, 3'b111};
    lane_bits = orig;
    lane_colours = cols;
    run_pass(1600, 100, -1, 1'b0);
    bad = 0;
    for (int i = 0; i < NPIX; i++)
      if (cap_c[i] !== exp_c(i, orig, cols, 1'b0) || cap_x[i] !== 8'(exp_x(i))) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL snapshot_pixels: %0d plots differ from snapshot, required 0", bad);
    end
    n_checks++;
    if (cap_n != NPIX || done_cnt != 1 || done_k != 1441) begin
      n_fail++;
      $display("FAIL snapshot_no_restart: plots=%0d dones=%0d done_at=%0d, required 1440 1 1441",
               cap_n, done_cnt, done_k);
    end
  endtask

  task automatic test_reset_mid;
    lane_bits = '1;
    lane_colours = {C_BLUE, C_YELLOW, C_RED};
    run_pass(600, -1, 500, 1'b0);
    n_checks++;
    if (rst_plot !== 1'b0 || rst_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: plot=%b busy=%b, required 0 0", rst_plot, rst_busy);
    end
    n_checks++;
    if (cap_n != 500 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_mid_abandon: plots=%0d dones=%0d, required 500 0", cap_n, done_cnt);
    end
    run_pass(1600, -1, -1, 1'b0);
    n_checks++;
    if (cap_x[0] !== 8'd1 || cap_y[0] !== 7'd53 || cap_n != NPIX || done_k != 1441) begin
      n_fail++;
      $display("FAIL reset_restart: x=%0d y=%0d plots=%0d done_at=%0d, required 1 53 1440 1441",
               cap_x[0], cap_y[0], cap_n, done_k);
    end
  endtask

  task automatic test_back_to_back;
    lane_bits = '0;
    lane_bits[0] = 1'b1;
    lane_colours = {C_BLUE, C_YELLOW, C_RED};
    run_pass(3100, -1, -1, 1'b1);
    n_checks++;
    if (cap_n != 2 * NPIX || done_cnt != 2 || done_k2 != 2883) begin
      n_fail++;
      $display("FAIL back_to_back: plots=%0d dones=%0d second_done=%0d, required 2880 2 2883",
               cap_n, done_cnt, done_k2);
    end
    n_checks++;
    if (cap_x[NPIX] !== 8'd1 || cap_y[NPIX] !== 7'd53 || cap_c[NPIX] !== C_RED) begin
      n_fail++;
      $display("FAIL back_to_back_first: x=%0d y=%0d c=%0d, required 1 53 4",
               cap_x[NPIX], cap_y[NPIX], cap_c[NPIX]);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    lane_bits = '0;
    lane_colours = '0;
    test_reset;
    test_first_bit;
    test_last_bit;
    test_clear;
    test_snapshot;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
